// File: rtl/clock_display_pkg.sv
// Shared constants and types for the six-digit clock display scanner.
// Segment patterns are logical active-high, ordered {g,f,e,d,c,b,a}.
package clock_display_pkg;

  localparam int NUM_DIGITS = 6;

  typedef enum logic {
    ON    = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/clock_display_scanner_if.sv
// Digit inputs from the clock counter and the multiplexed display pins.
// The scanner sits on the slave side; the counter/board side is the master.
interface clock_display_scanner_if;
  import clock_display_pkg::*;

  logic [3:0]            sec_ones;
  logic [3:0]            sec_tens;
  logic [3:0]            min_ones;
  logic [3:0]            min_tens;
  logic [3:0]            hour_ones;
  logic [3:0]            hour_tens;
  logic [6:0]            seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] an;
  logic                  frame_start;

  modport master (
    output sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens,
    output seg, dp, an, frame_start
  );

endinterface

// File: rtl/clock_display_scanner_bcd_to_seg.sv
// BCD digit to logical seven-segment pattern; non-BCD codes show a dash.
module bcd_to_seg
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_scanner.sv
// Six-digit multiplexed seven-segment scanner with per-frame snapshot,
// anti-ghosting blank tail per slot, hour-tens zero blanking and blinking dots.
//
//   state | meaning
//   ON    | digit idx driven with its snapshot pattern
//   BLANK | all digits off before idx advances
module clock_display_scanner
  import clock_display_pkg::*;
#(
  parameter int CLOCK_FREQ   = 50_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 500,
  parameter int COMMON_ANODE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  clock_display_scanner_if.slave  bus
);

  localparam int DIGIT_CYCLES = CLOCK_FREQ / SCAN_HZ;
  localparam int ON_CYCLES    = DIGIT_CYCLES - BLANK_CYCLES;
  localparam int CNT_W        = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(DIGIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ON_LAST = CNT_W'(ON_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST    = 3'(NUM_DIGITS - 1);
  localparam logic             INV         = (COMMON_ANODE != 0);

  generate
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_param_check
      $error("clock_display_scanner: need 1 <= BLANK_CYCLES < DIGIT_CYCLES");
    end
  endgenerate

  scan_state_t           state;
  logic [2:0]            idx;
  logic [CNT_W-1:0]      cnt;
  logic [3:0]            snap [NUM_DIGITS];
  logic [3:0]            cur_digit;
  logic [6:0]            cur_seg;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  frame_start_q;

  always_comb begin
    cur_digit = snap[0];
    case (idx)
      3'd1:    cur_digit = snap[1];
      3'd2:    cur_digit = snap[2];
      3'd3:    cur_digit = snap[3];
      3'd4:    cur_digit = snap[4];
      3'd5:    cur_digit = snap[5];
      default: cur_digit = snap[0];
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ON;
      idx           <= '0;
      cnt           <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= '0;
      an_q          <= {NUM_DIGITS{INV}};
      seg_q         <= {7{INV}};
      dp_q          <= INV;
      frame_start_q <= 1'b0;
    end else begin
      // Look one cycle ahead so the pulse lands in the snapshot-load cycle.
      frame_start_q <= (idx == IDX_LAST) && (cnt == CNT_PRELAST);

      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        state <= ON;
        idx   <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        if (idx == IDX_LAST) begin
          snap[0] <= bus.sec_ones;
          snap[1] <= bus.sec_tens;
          snap[2] <= bus.min_ones;
          snap[3] <= bus.min_tens;
          snap[4] <= bus.hour_ones;
          snap[5] <= bus.hour_tens;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_ON_LAST) state <= BLANK;
      end

      if (state == ON) begin
        if (idx == IDX_LAST && snap[5] == 4'd0) begin
          an_q  <= {NUM_DIGITS{INV}};
          seg_q <= SEG_OFF ^ {7{INV}};
        end else begin
          an_q  <= (NUM_DIGITS'(1) << idx) ^ {NUM_DIGITS{INV}};
          seg_q <= cur_seg ^ {7{INV}};
        end
        dp_q <= ((idx == 3'd2 || idx == 3'd4) && !snap[0][0]) ^ INV;
      end else begin
        an_q  <= {NUM_DIGITS{INV}};
        seg_q <= SEG_OFF ^ {7{INV}};
        dp_q  <= INV;
      end
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_clock_display_scanner.sv
// Bench for clock_display_scanner: directed scenarios plus random digit churn,
// every cycle compared against a frame/slot arithmetic model of the display.
module tb_clock_display_scanner;

  localparam int DC    = 10;      // cycles per digit slot
  localparam int ONC   = 8;       // lit cycles per slot
  localparam int FRAME = 6 * DC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  clock_display_scanner_if bus ();

  clock_display_scanner #(
    .CLOCK_FREQ   (1000),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (2),
    .COMMON_ANODE (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int passes = 0;
  int k = 0;                 // cycles since the last reset-sampling edge
  logic [3:0] din       [6];
  logic [3:0] snap_state[6]; // snapshot held by the scanner during cycle k
  logic [3:0] snap_pin  [6]; // snapshot behind the pins during cycle k

  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'd0: pat = 7'b0111111;
      4'd1: pat = 7'b0000110;
      4'd2: pat = 7'b1011011;
      4'd3: pat = 7'b1001111;
      4'd4: pat = 7'b1100110;
      4'd5: pat = 7'b1101101;
      4'd6: pat = 7'b1111101;
      4'd7: pat = 7'b0000111;
      4'd8: pat = 7'b1111111;
      4'd9: pat = 7'b1101111;
      default: pat = 7'b1000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
  endtask

  task automatic drive();
    bus.sec_ones  = din[0];
    bus.sec_tens  = din[1];
    bus.min_ones  = din[2];
    bus.min_tens  = din[3];
    bus.hour_ones = din[4];
    bus.hour_tens = din[5];
  endtask

  // Called at a negedge: check cycle k, drive inputs, advance the model.
  task automatic tick(input bit rst_req);
    logic [5:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    logic       fs_e;
    int         s;
    int         slot;
    bit         on;
    an_e = 6'h3F; seg_e = 7'h7F; dp_e = 1'b1; fs_e = 1'b0;
    if (k > 0) begin
      s    = k - 1;
      slot = (s / DC) % 6;
      on   = (s % DC) < ONC;
      fs_e = ((k % FRAME) == FRAME - 1);
      if (on && !(slot == 5 && snap_pin[5] == 4'd0)) begin
        an_e  = ~(6'b1 << slot);
        seg_e = ~pat(snap_pin[slot]);
      end
      if (on && (slot == 2 || slot == 4) && snap_pin[0][0] == 1'b0) dp_e = 1'b0;
    end
    chk("an", 32'(bus.an), 32'(an_e));
    chk("seg", 32'(bus.seg), 32'(seg_e));
    chk("dp", 32'(bus.dp), 32'(dp_e));
    chk("frame_start", 32'(bus.frame_start), 32'(fs_e));
    chk("an_overlap", 32'($countones(~bus.an) <= 1), 32'd1);

    drive();
    reset = ~rst_req;
    if (rst_req) begin
      k = 0;
      for (int i = 0; i < 6; i++) snap_state[i] = 4'd0;
      for (int i = 0; i < 6; i++) snap_pin[i] = 4'd0;
    end else begin
      for (int i = 0; i < 6; i++) snap_pin[i] = snap_state[i];
      if ((k % FRAME) == FRAME - 1)
        for (int i = 0; i < 6; i++) snap_state[i] = din[i];
      k++;
    end
    @(negedge clk);
  endtask

  task automatic run_until(input int m);
    int guard;
    guard = 0;
    while ((k % FRAME) != m && guard < 2 * FRAME) begin
      tick(1'b0);
      guard++;
    end
    chk("run_until_bound", 32'(k % FRAME), 32'(m));
  endtask

  task automatic churn(input int n);
    for (int c = 0; c < n; c++) begin
      if ($urandom_range(0, 7) == 0)
        din[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
      tick(1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      din[i] = 4'd0; snap_state[i] = 4'd0; snap_pin[i] = 4'd0;
    end
    drive();
    reset = 1'b0;
    @(negedge clk);

    // Held reset: pins inactive every cycle
    repeat (5) tick(1'b1);

    // 12:34:56
    din[0] = 4'd6; din[1] = 4'd5; din[2] = 4'd4;
    din[3] = 4'd3; din[4] = 4'd2; din[5] = 4'd1;
    repeat (2 * FRAME) tick(1'b0);

    // 09:xx:xx, hour tens blanked
    din[5] = 4'd0; din[4] = 4'd9;
    repeat (2 * FRAME) tick(1'b0);

    // Mid-frame input change must not tear the frame
    din[0] = 4'd5;
    repeat (FRAME) tick(1'b0);
    run_until(3 * DC);
    din[0] = 4'd6;
    repeat (FRAME + 30) tick(1'b0);

    // Invalid BCD dash and odd seconds (dots off)
    din[1] = 4'hC; din[0] = 4'd7;
    repeat (2 * FRAME) tick(1'b0);

    // Random digits including invalid codes
    churn(4 * FRAME);

    // One-cycle reset during the idx-4 lit slot
    run_until(4 * DC + 3);
    tick(1'b1);
    churn(2 * FRAME + 10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/clock_display_scanner.md
# clock_display_scanner

Time-multiplexed six-digit seven-segment driver sitting directly downstream of the digital clock counter. Consumes the six BCD time digits (HH:MM:SS), snapshots them once per frame, and scans them onto a shared segment bus with per-digit anti-ghosting blanking. It also handles leading-zero suppression on the hour tens digit, a blinking separator dot and invalid-BCD marking.

## Interface
Parameters:
- `CLOCK_FREQ`, 50_000_000: input clock frequency in Hz.
- `SCAN_HZ`, 1000: digit-slot rate in Hz. `DIGIT_CYCLES = CLOCK_FREQ / SCAN_HZ` is the number of cycles per digit slot.
- `BLANK_CYCLES`, 500: cycles at the end of each slot with all digits off. Elaboration error unless `1 <= BLANK_CYCLES < DIGIT_CYCLES`.
- `COMMON_ANODE`, 1: when 1, `seg`, `dp` and `an` are driven active-low; when 0, active-high.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low (asserted when 0).
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens`, `hour_ones`, `hour_tens` in 4 each: BCD digits from the clock counter.
- `seg` out 7: segments {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point / separator.
- `an` out 6: digit enables. Bit i selects digit i; 0 = sec_ones … 5 = hour_tens.
- `frame_start` out 1: one-cycle pulse, coincident with the snapshot load.

## Operation
- Internal state:
  - `state` ∈ {ON, BLANK}
  - `idx` 0..5
  - `cnt` 0..DIGIT_CYCLES-1
  - six 4-bit snapshot registers
- Slot sequencing:
  - ON: cycles `cnt` = 0 .. DIGIT_CYCLES-BLANK_CYCLES-1.
  - BLANK: the remaining BLANK_CYCLES cycles.
  - At the end of BLANK, `cnt` returns to 0 and `idx` advances; idx 5 wraps to 0.
- Snapshot:
  - All six inputs are loaded together on the last BLANK cycle of idx 5. `frame_start` pulses in that cycle.
  - Input changes at any other time are ignored until the next frame, so a rollover never tears a frame.
- Decode, logical active-high, applied in ON state only:
  - Digits 0–9 map to standard patterns.
  - Values 10–15 display a dash (g only, 7'b1000000).
- Leading-zero blanking: when snapshot hour_tens == 0, `an[5]` stays inactive for its ON slot and `seg` is all-off.
- Separator:
  - `dp` is asserted in the ON slots of idx 2 and idx 4 only, and only when snapshot `sec_ones[0] == 0`.
  - The dot therefore blinks at 0.5 Hz period per second pair.
- BLANK state: `an`, `seg` and `dp` are all inactive.
- Polarity: when COMMON_ANODE=1, `seg`, `dp` and `an` are inverted at the pins. `frame_start` is always active-high.

## Timing
- Reset (`reset`=0 at a clk edge):
  - Next cycle: `an`, `seg` and `dp` are inactive (all 1s when COMMON_ANODE=1), `frame_start`=0.
  - Snapshot clears to 0; `state`=ON, `idx`=0, `cnt`=0.
- Reset asserted mid-frame has the same effect. The scan restarts at idx 0 with zero snapshot; the first post-reset frame shows "0 00 00" with hour tens blanked.
- Outputs are registered, with 1-cycle latency from (`state`, `idx`, snapshot) to pins.
- First `an[0]` assertion occurs 1 cycle after the first post-reset ON cycle.
- Frame length is 6 × DIGIT_CYCLES cycles. `frame_start` period is exactly the same.
- No two `an` bits are ever simultaneously active. Every change of `idx` is separated by ≥ BLANK_CYCLES all-off cycles.
- Input sampled in the `frame_start` cycle is first visible on pins at the start of the next idx-0 ON slot, 2 cycles later.

## Structure
- Package `clock_display_pkg`:
  - `NUM_DIGITS`=6
  - the `scan_state_t` enum {ON, BLANK}
  - segment constants `SEG_DIGIT[0:9]`, `SEG_DASH`, `SEG_OFF`
- One sub-module, `bcd_to_seg`: combinational 4-bit BCD → 7-bit logical segment pattern, with dash for 10–15.
- Top level holds the counters, FSM, snapshot, blanking/dp logic, polarity inversion and output registers.

## Test plan
Common parameters: CLOCK_FREQ=1000, SCAN_HZ=100, BLANK_CYCLES=2, COMMON_ANODE=1. This gives DIGIT_CYCLES=10 (8 ON + 2 BLANK).

1. Reset: hold `reset`=0 for 5 cycles → `an`=6'b111111, `seg`=7'b1111111, `dp`=1, `frame_start`=0 throughout.
2. Inputs 12:34:56 (hour_tens=1, hour_ones=2, min_tens=3, min_ones=4, sec_tens=5, sec_ones=6), run 2 frames:
   - Second frame digit 0: `an`=6'b111110, `seg`=7'b0000010 for 8 cycles, then 2 cycles `an`=6'b111111.
   - Digits 1–5 follow in order.
   - `dp`=0 during idx 2 and 4 (6 is even); `dp`=1 elsewhere.
3. hour_tens=0, hour_ones=9 → `an[5]` never asserted in slot 5 and `seg`=7'b1111111 there. Slot 4 shows 9 (`seg`=7'b0010000).
4. sec_ones changed 5→6 during the idx-3 slot → digit 0 still shows 5 (7'b0010010) for the rest of that frame; shows 6 after the next `frame_start`.
5. sec_tens=4'hC → slot 1 shows dash: `seg`=7'b0111111. Check sec_ones odd → `dp`=1 (off) in all slots.
6. Assert `reset`=0 for 1 cycle during idx 4 ON:
   - Next cycle all outputs are inactive.
   - Scan resumes at idx 0 showing 0.
   - No overlap of `an` bits across the whole run, asserted continuously.
